// File: rtl/radix4_serial_multiplier_pkg.sv
// rtl/radix4_serial_multiplier_pkg.sv - shared widths, iteration count and state type
package radix4_serial_multiplier_pkg;

    localparam int MCAND_W  = 23;
    localparam int MPLR_W   = 24;
    localparam int PROD_W   = 47;
    localparam int A_W      = 45;
    localparam int B_W      = 2;
    localparam int ITER_CNT = 12;

    // Y3 = 3*Y needs two extra bits; the accumulator keeps a 25-bit upper
    // partial sum above the 24 product bits shifted out of the bottom.
    localparam int Y3_W  = MCAND_W + 2;
    localparam int ACC_W = Y3_W + MPLR_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/radix4_digit_select.sv
// rtl/radix4_digit_select.sv - picks 0, Y, 2Y or 3Y from a radix-4 multiplier digit
module radix4_digit_select
    import radix4_serial_multiplier_pkg::*;
(
    input  logic [1:0]         i_digit,
    input  logic [MCAND_W-1:0] i_y,
    input  logic [Y3_W-1:0]    i_y3,
    output logic [Y3_W-1:0]    o_mult
);

    // 4:1 multiple select; 3Y is precomputed so no adder sits in this path
    always_comb begin
        o_mult = '0;
        case (i_digit)
            2'd0:    o_mult = '0;
            2'd1:    o_mult = {2'b00, i_y};
            2'd2:    o_mult = {1'b0, i_y, 1'b0};
            default: o_mult = i_y3;
        endcase
    end

endmodule

// File: rtl/radix4_serial_multiplier.sv
// rtl/radix4_serial_multiplier.sv - 24x23 radix-4 serial multiplier feeding the rounding adder; ROUND_EN enables P[1] round-half-up increment
module radix4_serial_multiplier
    import radix4_serial_multiplier_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MPLR_W-1:0]  X,
    input  logic [MCAND_W-1:0] Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W-1:0]     A,
    output logic [B_W-1:0]     B
);

    state_t             r_state;
    logic [MPLR_W-1:0]  r_x;
    logic [MCAND_W-1:0] r_y;
    logic [Y3_W-1:0]    r_y3;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [A_W-1:0]     r_a;

    logic [Y3_W-1:0]    w_mult;
    logic [Y3_W:0]      w_sum;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_unused;

    radix4_digit_select u_digit_select (
        .i_digit (r_x[1:0]),
        .i_y     (r_y),
        .i_y3    (r_y3),
        .o_mult  (w_mult)
    );

    // Add the selected multiple to the upper partial sum, then shift the whole
    // accumulator right by one digit so two finished product bits drop below it.
    assign w_sum      = {1'b0, r_acc[ACC_W-1 -: Y3_W]} + {1'b0, w_mult};
    assign w_acc_next = {1'b0, w_sum, r_acc[MPLR_W-1:2]};

    // Top two accumulator bits are always zero because P < 2^47; the lowest
    // bits are only consumed by the rounding path.
    assign w_unused = ^{r_acc[1:0], w_acc_next[ACC_W-1:PROD_W], w_acc_next[1:0]};

`ifdef ROUND_EN
    logic r_round;

    // Capture P[1] as the round-half-up increment when the product completes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_round <= 1'b0;
        end else if (r_state == RUN && r_cnt == CNT_W'(ITER_CNT - 1)) begin
            r_round <= w_acc_next[1];
        end
    end

    assign B = {1'b0, r_round};
`else
    assign B = '0;
`endif

    // Sequencer: accept, precompute 3Y, twelve digit iterations, hold result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_y3        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_a         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x        <= X;
                        r_y        <= Y;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= PRE;
                    end
                end
                PRE: begin
                    r_y3    <= {2'b00, r_y} + {1'b0, r_y, 1'b0};
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_x   <= {2'b00, r_x[MPLR_W-1:2]};
                    if (r_cnt == CNT_W'(ITER_CNT - 1)) begin
                        r_a         <= w_acc_next[PROD_W-1:2];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign A         = r_a;

endmodule

// File: tb/tb_radix4_serial_multiplier.sv
// tb/tb_radix4_serial_multiplier.sv - scoreboard bench for radix4_serial_multiplier
module tb_radix4_serial_multiplier;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] X;
    logic [22:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [44:0] A;
    logic [1:0]  B;

    int checks = 0;
    int errors = 0;
    int results = 0;
    logic [46:0] q_exp[$];

    radix4_serial_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A         (A),
        .B         (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [46:0] model(logic [23:0] x, logic [22:0] y);
        logic [46:0] p;
        logic [1:0]  b;
        p = 47'(x) * 47'(y);
`ifdef ROUND_EN
        b = {1'b0, p[1]};
`else
        b = 2'b00;
`endif
        return {p[46:2], b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [23:0] x, input logic [22:0] y);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        X = x;
        Y = y;
        step();
        in_valid = 1'b0;
        q_exp.push_back(model(x, y));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("out_valid_seen", 64'(out_valid), 64'd1);
    endtask

    task automatic check_result(input string tag);
        logic [46:0] e;
        if (q_exp.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = q_exp.pop_front();
            chk({tag, "_A"}, 64'(A), 64'(e[46:2]));
            chk({tag, "_B"}, 64'(B), 64'(e[1:0]));
            results++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic quiet_window(input string tag);
        int hits;
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) hits++;
            step();
        end
        chk(tag, 64'(hits), 64'd0);
    endtask

    initial begin
        int lat;
        int guard;
        int got;
        logic [44:0] a_hold;
        logic [1:0]  b_hold;
        logic [1:0]  b_exp;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        X = '0;
        Y = '0;
        step();
        step();
        rst_n = 1'b1;

        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_A", 64'(A), 64'd0);
        chk("rst_B", 64'(B), 64'd0);

        // 3*5 = 15, latency measured from the accept edge
        send(24'd3, 23'd5);
        wait_out(lat);
        chk("latency", 64'(lat), 64'd13);
        chk("p15_A_const", 64'(A), 64'd3);
`ifdef ROUND_EN
        b_exp = 2'd1;
`else
        b_exp = 2'd0;
`endif
        chk("p15_B_const", 64'(B), 64'(b_exp));
        check_result("p15");
        take_result();
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // largest operands
        send(24'hFFFFFF, 23'h7FFFFF);
        wait_out(lat);
        chk("max_A_const", 64'(A), 64'h1FFFFFA00000);
        chk("max_B_const", 64'(B), 64'd0);
        check_result("max");
        take_result();

        // 2*1 = 2: discarded bits are exactly one half
        send(24'd2, 23'd1);
        wait_out(lat);
        chk("p2_A_const", 64'(A), 64'd0);
        chk("p2_B_const", 64'(B), 64'(b_exp));
        check_result("p2");
        take_result();

        // zero multiplier
        send(24'd0, 23'h5A5A5A);
        wait_out(lat);
        check_result("zero");
        take_result();

        // backpressure in DONE with a competing in_valid
        send(24'hABCDEF, 23'h123456);
        wait_out(lat);
        a_hold = A;
        b_hold = B;
        in_valid = 1'b1;
        X = 24'd7;
        Y = 23'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_A_stable", 64'(A), 64'(a_hold));
            chk("bp_B_stable", 64'(B), 64'(b_hold));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check_result("bp");
        take_result();
        quiet_window("bp_no_extra_result");

        // reset during RUN at counter 5
        send(24'h3C3C3C, 23'h0F0F0F);
        for (int i = 0; i < 6; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        void'(q_exp.pop_back());
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_A", 64'(A), 64'd0);
        chk("midrst_B", 64'(B), 64'd0);
        quiet_window("midrst_no_result");
        send(24'h123456, 23'h654321);
        wait_out(lat);
        chk("postrst_latency", 64'(lat), 64'd13);
        check_result("postrst");
        take_result();

        // back-to-back random operands with random out_ready
        results = 0;
        for (int n = 0; n < 200; n++) begin
            send(24'($urandom), 23'($urandom));
            got = 0;
            guard = 0;
            while (!got && guard < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check_result("rand");
                    got = 1;
                end
                step();
                guard++;
            end
            out_ready = 1'b0;
            if (!got) chk("rand_timeout", 64'd0, 64'd1);
        end
        chk("rand_count", 64'(results), 64'd200);
        chk("sb_empty", 64'(q_exp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
